trap_sequencer: RTL and testbench

Trap and `mret` controller placed between the single-cycle core and the machine-mode CSR file. It runs the multi-cycle trap-entry sequence: write `mepc`, write `mcause`, read-modify-write `mstatus`, read `mtvec`, then redirect. It also runs the `mret` sequence. It owns the CSR file's single access port while a sequence is in progress and passes the core's CSR port straight through when idle.

---
 rtl/trap_sequencer.sv | 150 +++++++++++++++
 tb/tb_trap_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_sequencer.sv
// Trap-entry and mret sequencer owning the machine-mode CSR port while busy.
// Optional vectored interrupt targets are enabled with `define TRAP_VECTORED_EN.
//
// state    | meaning
// IDLE     | core CSR port passes through; requests sampled here
// T_EPC    | write latched PC to mepc
// T_CAUSE  | write latched cause to mcause
// T_STATUS | read-modify-write mstatus for trap entry
// T_VEC    | read mtvec and register redirect target
// M_STATUS | read-modify-write mstatus for mret
// M_EPC    | read mepc and register redirect target
// REDIRECT | pulse trap_ack / redirect_valid, then back to IDLE

module trap_sequencer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        trap_req,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_pc,
    input  logic        mret_req,
    output logic        busy,
    output logic        trap_ack,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic [11:0] core_csr_addr,
    input  logic        core_csr_read_en,
    input  logic        core_csr_write_en,
    input  logic [31:0] core_csr_write_data,
    output logic [31:0] core_csr_read_data,
    output logic [11:0] csr_addr,
    output logic        csr_read_en,
    output logic        csr_write_en,
    output logic [31:0] csr_write_data,
    input  logic [31:0] csr_read_data
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

    typedef enum logic [2:0] {
        IDLE, T_EPC, T_CAUSE, T_STATUS, T_VEC, M_STATUS, M_EPC, REDIRECT
    } state_t;

    state_t      state;
    logic [31:0] cause_q;
    logic [31:0] pc_q;
    logic [31:0] status_trap;
    logic [31:0] status_mret;
    logic [31:0] vec_target;

    always_comb begin
        status_trap        = csr_read_data;
        status_trap[7]     = csr_read_data[3];
        status_trap[3]     = 1'b0;
        status_trap[12:11] = 2'b11;

        status_mret        = csr_read_data;
        status_mret[3]     = csr_read_data[7];
        status_mret[7]     = 1'b1;
        status_mret[12:11] = 2'b11;

        vec_target = csr_read_data & ~32'h3;
`ifdef TRAP_VECTORED_EN
        // cause[30:0] << 2 truncated to 32 bits keeps only cause[29:0]
        if (csr_read_data[1:0] == 2'b01 && cause_q[31])
            vec_target = (csr_read_data & ~32'h3) + {cause_q[29:0], 2'b00};
`endif
    end

    always_comb begin
        csr_addr           = core_csr_addr;
        csr_read_en        = core_csr_read_en;
        csr_write_en       = core_csr_write_en;
        csr_write_data     = core_csr_write_data;
        core_csr_read_data = csr_read_data;
        if (state != IDLE) begin
            csr_addr           = 12'h000;
            csr_read_en        = 1'b0;
            csr_write_en       = 1'b0;
            csr_write_data     = 32'h0;
            core_csr_read_data = 32'h0;
            case (state)
                T_EPC:    begin csr_addr = ADDR_MEPC;    csr_write_en = 1'b1; csr_write_data = pc_q; end
                T_CAUSE:  begin csr_addr = ADDR_MCAUSE;  csr_write_en = 1'b1; csr_write_data = cause_q; end
                T_STATUS: begin csr_addr = ADDR_MSTATUS; csr_read_en = 1'b1; csr_write_en = 1'b1;
                                csr_write_data = status_trap; end
                T_VEC:    begin csr_addr = ADDR_MTVEC;   csr_read_en = 1'b1; end
                M_STATUS: begin csr_addr = ADDR_MSTATUS; csr_read_en = 1'b1; csr_write_en = 1'b1;
                                csr_write_data = status_mret; end
                M_EPC:    begin csr_addr = ADDR_MEPC;    csr_read_en = 1'b1; end
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            busy           <= 1'b0;
            trap_ack       <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'h0;
            cause_q        <= 32'h0;
            pc_q           <= 32'h0;
        end else begin
            trap_ack       <= 1'b0;
            redirect_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (trap_req) begin
                        cause_q <= trap_cause;
                        pc_q    <= trap_pc & ~32'h3;
                        busy    <= 1'b1;
                        state   <= T_EPC;
                    end else if (mret_req) begin
                        busy  <= 1'b1;
                        state <= M_STATUS;
                    end
                end
                T_EPC:    state <= T_CAUSE;
                T_CAUSE:  state <= T_STATUS;
                T_STATUS: state <= T_VEC;
                T_VEC: begin
                    redirect_pc    <= vec_target;
                    trap_ack       <= 1'b1;
                    redirect_valid <= 1'b1;
                    state          <= REDIRECT;
                end
                M_STATUS: state <= M_EPC;
                M_EPC: begin
                    redirect_pc    <= csr_read_data & ~32'h3;
                    trap_ack       <= 1'b1;
                    redirect_valid <= 1'b1;
                    state          <= REDIRECT;
                end
                REDIRECT: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer with a small behavioural CSR file attached.
module tb_trap_sequencer;

    logic        clk;
    logic        reset_n;
    logic        trap_req;
    logic [31:0] trap_cause;
    logic [31:0] trap_pc;
    logic        mret_req;
    logic        busy;
    logic        trap_ack;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [11:0] core_csr_addr;
    logic        core_csr_read_en;
    logic        core_csr_write_en;
    logic [31:0] core_csr_write_data;
    logic [31:0] core_csr_read_data;
    logic [11:0] csr_addr;
    logic        csr_read_en;
    logic        csr_write_en;
    logic [31:0] csr_write_data;
    logic [31:0] csr_read_data;

    logic [31:0] m_status = 32'h0;
    logic [31:0] m_vec    = 32'h0;
    logic [31:0] m_epc    = 32'h0;
    logic [31:0] m_cause  = 32'h0;

    int n_checks = 0;
    int n_pass   = 0;

    trap_sequencer dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .trap_req            (trap_req),
        .trap_cause          (trap_cause),
        .trap_pc             (trap_pc),
        .mret_req            (mret_req),
        .busy                (busy),
        .trap_ack            (trap_ack),
        .redirect_valid      (redirect_valid),
        .redirect_pc         (redirect_pc),
        .core_csr_addr       (core_csr_addr),
        .core_csr_read_en    (core_csr_read_en),
        .core_csr_write_en   (core_csr_write_en),
        .core_csr_write_data (core_csr_write_data),
        .core_csr_read_data  (core_csr_read_data),
        .csr_addr            (csr_addr),
        .csr_read_en         (csr_read_en),
        .csr_write_en        (csr_write_en),
        .csr_write_data      (csr_write_data),
        .csr_read_data       (csr_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CSR file: combinational read, write on the rising edge
    always_comb begin
        case (csr_addr)
            12'h300: csr_read_data = m_status;
            12'h305: csr_read_data = m_vec;
            12'h341: csr_read_data = m_epc;
            12'h342: csr_read_data = m_cause;
            default: csr_read_data = 32'h0;
        endcase
    end

    always @(posedge clk) begin
        if (csr_write_en) begin
            case (csr_addr)
                12'h300: m_status <= csr_write_data;
                12'h305: m_vec    <= csr_write_data;
                12'h341: m_epc    <= csr_write_data;
                12'h342: m_cause  <= csr_write_data;
                default: ;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic core_write(input logic [11:0] addr, input logic [31:0] data);
        core_csr_addr       = addr;
        core_csr_write_data = data;
        core_csr_write_en   = 1'b1;
        @(negedge clk);
        core_csr_write_en   = 1'b0;
    endtask

    task automatic core_read(input logic [11:0] addr, output logic [31:0] data);
        core_csr_addr    = addr;
        core_csr_read_en = 1'b1;
        #1;
        data             = core_csr_read_data;
        core_csr_read_en = 1'b0;
    endtask

    // Called at a falling edge; the next rising edge is the acceptance edge.
    task automatic run_seq(input bit is_trap, input logic [31:0] cause, input logic [31:0] pc,
                           input bit core_wr, input int exp_lat, input logic [31:0] exp_pc,
                           input string tag);
        int ack_cycle;
        bit busy_ok;
        if (is_trap) begin
            trap_cause = cause;
            trap_pc    = pc;
            trap_req   = 1'b1;
        end else begin
            mret_req = 1'b1;
        end
        @(posedge clk);
        #1;
        if (core_wr) begin
            core_csr_addr       = 12'h305;
            core_csr_write_data = 32'h0000_DEAD;
            core_csr_write_en   = 1'b1;
            core_csr_read_en    = 1'b1;
        end
        ack_cycle = 0;
        busy_ok   = 1'b1;
        for (int k = 1; k <= 12 && ack_cycle == 0; k++) begin
            @(negedge clk);
            if (!busy || core_csr_read_data != 32'h0) busy_ok = 1'b0;
            if (trap_ack) begin
                ack_cycle = k;
                check({tag, "_redirect_valid"}, {31'h0, redirect_valid}, 32'h1);
                check({tag, "_redirect_pc"}, redirect_pc, exp_pc);
                if (is_trap) trap_req = 1'b0;
                else mret_req = 1'b0;
                core_csr_write_en = 1'b0;
                core_csr_read_en  = 1'b0;
            end
        end
        if (ack_cycle == 0) begin
            trap_req          = 1'b0;
            mret_req          = 1'b0;
            core_csr_write_en = 1'b0;
            core_csr_read_en  = 1'b0;
        end
        check({tag, "_ack_cycle"}, ack_cycle, exp_lat);
        check({tag, "_busy_held"}, {31'h0, busy_ok}, 32'h1);
        @(negedge clk);
        check({tag, "_idle_after"}, {29'h0, busy, trap_ack, redirect_valid}, 32'h0);
    endtask

    logic [31:0] rd;
    logic [31:0] exp_vec_pc;

    initial begin
        reset_n             = 1'b0;
        trap_req            = 1'b0;
        mret_req            = 1'b0;
        trap_cause          = 32'h0;
        trap_pc             = 32'h0;
        core_csr_addr       = 12'h0;
        core_csr_read_en    = 1'b0;
        core_csr_write_en   = 1'b0;
        core_csr_write_data = 32'h0;

        // reset with random request traffic
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            trap_req      = 1'($urandom);
            mret_req      = 1'($urandom);
            trap_cause    = $urandom;
            trap_pc       = $urandom;
            core_csr_addr = 12'($urandom);
        end
        @(negedge clk);
        check("rst_outputs", {29'h0, busy, trap_ack, redirect_valid}, 32'h0);
        check("rst_redirect_pc", redirect_pc, 32'h0);
        core_write(12'h305, 32'h0000_0100);
        core_read(12'h305, rd);
        check("rst_passthru_mtvec", rd, 32'h0000_0100);
        check("rst_passthru_addr", {20'h0, csr_addr}, 32'h0000_0305);
        trap_req = 1'b0;
        mret_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // exception entry
        core_write(12'h300, 32'h0000_0008);
        run_seq(1'b1, 32'h2, 32'h0000_0042, 1'b0, 5, 32'h0000_0100, "exc");
        check("exc_mepc", m_epc, 32'h0000_0040);
        check("exc_mcause", m_cause, 32'h0000_0002);
        check("exc_mstatus", m_status, 32'h0000_1880);

        // mret
        core_write(12'h341, 32'h0000_0044);
        run_seq(1'b0, 32'h0, 32'h0, 1'b0, 3, 32'h0000_0044, "mret");
        check("mret_mstatus", m_status, 32'h0000_1888);

        // vectored interrupt
`ifdef TRAP_VECTORED_EN
        exp_vec_pc = 32'h0000_011C;
`else
        exp_vec_pc = 32'h0000_0100;
`endif
        core_write(12'h305, 32'h0000_0101);
        run_seq(1'b1, 32'h8000_0007, 32'h0000_0010, 1'b0, 5, exp_vec_pc, "vec");
        check("vec_mcause", m_cause, 32'h8000_0007);

        // simultaneous requests with a blocked core write
        core_write(12'h305, 32'h0000_0100);
        core_write(12'h300, 32'h0000_0008);
        mret_req = 1'b1;
        run_seq(1'b1, 32'h3, 32'h0000_0080, 1'b1, 5, 32'h0000_0100, "sim_trap");
        check("sim_mepc", m_epc, 32'h0000_0080);
        check("sim_mstatus_trap", m_status, 32'h0000_1880);
        check("sim_mtvec_kept", m_vec, 32'h0000_0100);
        run_seq(1'b0, 32'h0, 32'h0, 1'b0, 3, 32'h0000_0080, "sim_mret");
        check("sim_mstatus_mret", m_status, 32'h0000_1888);

        // reset during T_CAUSE
        core_write(12'h300, 32'h0000_0008);
        trap_cause = 32'h5;
        trap_pc    = 32'h0000_0200;
        trap_req   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        reset_n  = 1'b0;
        trap_req = 1'b0;
        #1;
        check("midrst_outputs", {29'h0, busy, trap_ack, redirect_valid}, 32'h0);
        check("midrst_redirect_pc", redirect_pc, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("midrst_idle", {29'h0, busy, trap_ack, redirect_valid}, 32'h0);
        check("midrst_mepc_partial", m_epc, 32'h0000_0200);
        check("midrst_mcause_untouched", m_cause, 32'h0000_0003);
        run_seq(1'b1, 32'hB, 32'h0000_0303, 1'b0, 5, 32'h0000_0100, "retry");
        check("retry_mepc", m_epc, 32'h0000_0300);
        check("retry_mcause", m_cause, 32'h0000_000B);
        check("retry_mstatus", m_status, 32'h0000_1880);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
